// File: rtl/alu_issue_driver_if.sv
// rtl/alu_issue_driver_if.sv - request/response and ALU operand bus bundle for alu_issue_driver
//
// Signals:
//   req_*   : operation request (valid/ready, operands, op, mode, tag)
//   alu_*   : registered operand bus to the ALU, result and raw overflow flags back
//   rsp_*   : response (valid/ready, result, masked overflow, error, tag)
// Modports:
//   master : sequencer / ALU side (drives requests, ALU result, rsp_ready)
//   slave  : alu_issue_driver side
interface alu_issue_driver_if #(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [63:0]      req_x;
    logic [63:0]      req_y;
    logic [1:0]       req_ops;
    logic [2:0]       req_mode;
    logic [TAG_W-1:0] req_tag;

    logic [63:0]      alu_x;
    logic [63:0]      alu_y;
    logic [1:0]       alu_ops;
    logic [2:0]       alu_mode;
    logic [63:0]      alu_z;
    logic [6:0]       alu_ovf;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [63:0]      rsp_z;
    logic [3:0]       rsp_ovf;
    logic             rsp_err;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output req_valid, req_x, req_y, req_ops, req_mode, req_tag,
        input  req_ready,
        input  alu_x, alu_y, alu_ops, alu_mode,
        output alu_z, alu_ovf,
        input  rsp_valid, rsp_z, rsp_ovf, rsp_err, rsp_tag,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_x, req_y, req_ops, req_mode, req_tag,
        output req_ready,
        output alu_x, alu_y, alu_ops, alu_mode,
        input  alu_z, alu_ovf,
        output rsp_valid, rsp_z, rsp_ovf, rsp_err, rsp_tag,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_issue_driver.sv
// rtl/alu_issue_driver.sv - single-outstanding issue driver for the registered packed ALU
//
// Ports:
//   clock      : rising-edge clock
//   reset_n    : synchronous active-low reset
//   bus        : alu_issue_driver_if.slave (request, ALU operand bus, response)
//   ovf_clr    : clears the sticky overflow flag (only with ALU_ISSUE_STICKY_OVF_EN)
//   ovf_sticky : set when any captured masked overflow was nonzero (only with ALU_ISSUE_STICKY_OVF_EN)
// Parameters:
//   ALU_LATENCY : clock edges from operand drive until the ALU updates z
//   TAG_W       : request/response tag width
// Optional feature macro: ALU_ISSUE_STICKY_OVF_EN
module alu_issue_driver #(
    parameter int ALU_LATENCY = 1,
    parameter int TAG_W       = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    alu_issue_driver_if.slave   bus
`ifdef ALU_ISSUE_STICKY_OVF_EN
    ,
    input  logic                ovf_clr,
    output logic                ovf_sticky
`endif
);
    localparam int CNT_W = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LATENCY);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] OP_MAX  = 2'b10;
    localparam logic [1:0] OP_BAD  = 2'b11;
    localparam logic [2:0] MODE_64 = 3'b000;
    localparam logic [2:0] MODE_32 = 3'b001;
    localparam logic [2:0] MODE_16 = 3'b010;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [63:0]      alu_x_r;
    logic [63:0]      alu_y_r;
    logic [1:0]       alu_ops_r;
    logic [2:0]       alu_mode_r;
    logic [63:0]      rsp_z_r;
    logic [3:0]       rsp_ovf_r;
    logic             rsp_err_r;
    logic [TAG_W-1:0] rsp_tag_r;

    logic             req_illegal;
    logic [3:0]       ovf_masked;
    logic             capture;

    assign req_illegal = (bus.req_ops == OP_BAD) ||
                         !((bus.req_mode == MODE_64) || (bus.req_mode == MODE_32) ||
                           (bus.req_mode == MODE_16));

    assign capture = (state == S_WAIT) && (cnt == '0);

    // The ALU leaves stale flags for widths it is not currently using, so only
    // the flags of the issued mode are passed on; max never reports overflow.
    always_comb begin
        ovf_masked = 4'b0000;
        if (alu_ops_r != OP_MAX) begin
            case (alu_mode_r)
                MODE_64: ovf_masked = {3'b000, bus.alu_ovf[6]};
                MODE_32: ovf_masked = {2'b00, bus.alu_ovf[5], bus.alu_ovf[4]};
                MODE_16: ovf_masked = bus.alu_ovf[3:0];
                default: ovf_masked = 4'b0000;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            alu_x_r    <= '0;
            alu_y_r    <= '0;
            alu_ops_r  <= '0;
            alu_mode_r <= '0;
            rsp_z_r    <= '0;
            rsp_ovf_r  <= '0;
            rsp_err_r  <= 1'b0;
            rsp_tag_r  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        rsp_tag_r <= bus.req_tag;
                        if (req_illegal) begin
                            // Rejected without touching the ALU bus.
                            rsp_err_r <= 1'b1;
                            rsp_z_r   <= '0;
                            rsp_ovf_r <= '0;
                            state     <= S_RESP;
                        end else begin
                            alu_x_r    <= bus.req_x;
                            alu_y_r    <= bus.req_y;
                            alu_ops_r  <= bus.req_ops;
                            alu_mode_r <= bus.req_mode;
                            cnt        <= CNT_LOAD;
                            state      <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rsp_z_r   <= bus.alu_z;
                        rsp_ovf_r <= ovf_masked;
                        rsp_err_r <= 1'b0;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_ISSUE_STICKY_OVF_EN
    logic sticky_r;

    // Set has priority over clear when both land on the same edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sticky_r <= 1'b0;
        end else if (capture && (ovf_masked != 4'b0000)) begin
            sticky_r <= 1'b1;
        end else if (ovf_clr) begin
            sticky_r <= 1'b0;
        end
    end

    assign ovf_sticky = sticky_r;
`endif

    assign bus.req_ready = (state == S_IDLE);
    assign bus.rsp_valid = (state == S_RESP);
    assign bus.alu_x     = alu_x_r;
    assign bus.alu_y     = alu_y_r;
    assign bus.alu_ops   = alu_ops_r;
    assign bus.alu_mode  = alu_mode_r;
    assign bus.rsp_z     = rsp_z_r;
    assign bus.rsp_ovf   = rsp_ovf_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.rsp_tag   = rsp_tag_r;
endmodule
